ahb_slave_if_param: RTL and testbench
=====================================

// Module: ahb_slave_if_param
// PURPOSE
//  Parametrised AHB-side slave interface for the AHB-to-APB bridge. Qualifies AHB transfers and
//  decodes the address into one-hot APB slave selects. Pipelines address/write/data over a
//  configurable depth for the bridge FSM, and returns read data and the response to the AHB
//  master. Sits between the AHB interconnect and the APB controller FSM.
// PARAMETERS
//  AW          32             address width (>=8)
//  DW          32             data width (32 or 64)
//  NUM_SLV     3              number of APB slaves / decode regions (1..8)
//  BASE_ADDR   32'h8000_0000  base of region 0
//  REGION_SZ   32'h0400_0000  size of each region (power of 2); slave i = BASE_ADDR+i*REGION_SZ
//  PIPE_DEPTH  2              address/data pipeline stages (2..4)
// PORTS
//  Hclk       in   1              bridge clock, rising edge
//  Hresetn    in   1              asynchronous active-low reset
//  Hwrite     in   1              AHB write strobe
//  Hreadyin   in   1              AHB ready from interconnect
//  Htrans     in   2              AHB transfer type
//  Haddr      in   AW             AHB address
//  Hwdata     in   DW             AHB write data
//  Prdata     in   DW             read data from APB side
//  valid      out  1              qualified, mapped transfer this cycle
//  Haddr1     out  AW             address, pipeline stage 1
//  Haddr2     out  AW             address, stage PIPE_DEPTH
//  Hwdata1    out  DW             write data, stage 1
//  Hwdata2    out  DW             write data, stage PIPE_DEPTH
//  Hwritereg  out  1              registered Hwrite
//  tempselx   out  NUM_SLV        one-hot slave select (combinational)
//  Hrdata     out  DW             read data to master (= Prdata)
//  Hresp      out  2              AHB response (OKAY=00, ERROR=01)
//  Hreadyout  out  1              slave-side ready contribution
// BEHAVIOUR
//  - Reset (async, Hresetn=0): all pipeline regs, Hwritereg = 0; FSM -> IDLE; Hresp=OKAY, Hreadyout=1.
//  - Pipeline: when Hreadyin=1, stage1 <= Haddr/Hwdata and stage k <= stage k-1; hold when Hreadyin=0.
//    Haddr2 lags Haddr by PIPE_DEPTH accepted cycles. Hwritereg <= Hwrite when Hreadyin=1.
//  - hit: Haddr in [BASE_ADDR, BASE_ADDR+NUM_SLV*REGION_SZ); idx = (Haddr-BASE_ADDR)/REGION_SZ.
//  - tempselx = hit ? (1<<idx) : 0; purely combinational; never multi-hot.
//  - valid = Hreadyin & hit & Htrans in {NONSEQ(10), SEQ(11)} & (state==IDLE). IDLE/BUSY -> valid=0.
//  - Hrdata = Prdata, combinational pass-through, no latency.
//  - Error FSM states IDLE, ERR1, ERR2:
//      IDLE -> ERR1 on Hreadyin & ~hit & Htrans in {NONSEQ,SEQ}; ERR1 -> ERR2; ERR2 -> IDLE.
//      IDLE: Hresp=OKAY, Hreadyout=1. ERR1: Hresp=ERROR, Hreadyout=0. ERR2: Hresp=ERROR, Hreadyout=1.
//  - Htrans=IDLE arriving in ERR1: ignored; FSM still completes both ERROR cycles.
//  - Reset asserted mid-ERR1/ERR2: immediate IDLE, OKAY. Address at top of last region is a hit;
//    the address one past it is a miss. Address arithmetic is AW wide; no wrap across 2^AW.
// CONFIGURATION
//  AHB_SLV_ERR_RESP_EN defined: two-cycle ERROR response for unmapped addresses, as above.
//  Not defined: no FSM. Unmapped transfers give valid=0, tempselx=0, Hresp=OKAY, Hreadyout=1
//  (silently dropped).
// STRUCTURE
//  Shared package ahb_bridge_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, err-FSM state enum.
//  Sub-module ahb_addr_decoder (AW, NUM_SLV, BASE_ADDR, REGION_SZ): Haddr -> hit, tempselx.
//  Pipeline is a generate loop over PIPE_DEPTH in the top module.
// TESTING
//  1 Reset: Hresetn=0 for 2 cycles -> Haddr1/2=0, Hwritereg=0, Hresp=00, Hreadyout=1, valid=0.
//  2 Hreadyin=1, Htrans=10, Haddr=8400_0010 -> valid=1, tempselx=010;
//    Haddr2=8400_0010 after PIPE_DEPTH edges.
//  3 Hreadyin=0, Htrans=11, Haddr=8040_0000 -> valid=0, pipeline holds previous values.
//  4 Htrans=10, Haddr=8C00_1234 (unmapped, NUM_SLV=3), macro on -> Hresp=01 for 2 cycles,
//    Hreadyout 0 then 1, valid=0.
//  5 Same stimulus, macro off -> valid=0, tempselx=000, Hresp=00, Hreadyout=1.
//  6 Boundaries: Haddr=8BFF_FFFC -> tempselx=100; 7FFF_FFFC -> miss; reset during ERR1 -> IDLE.

Source files
------------

// File: rtl/ahb_bridge_pkg.sv
// Shared AHB-to-APB bridge definitions: transfer/response encodings and the
// error-response FSM state type.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_state_e;

endpackage

// File: rtl/ahb_slave_if_param_if.sv
// AHB-side bus bundle of the bridge slave interface; the master modport is the
// interconnect/APB-controller view, the slave modport is the bridge front end.
interface ahb_slave_if_param_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NUM_SLV = 3
);
  logic               Hwrite;
  logic               Hreadyin;
  logic [1:0]         Htrans;
  logic [AW-1:0]      Haddr;
  logic [DW-1:0]      Hwdata;
  logic [DW-1:0]      Prdata;
  logic               valid;
  logic [AW-1:0]      Haddr1;
  logic [AW-1:0]      Haddr2;
  logic [DW-1:0]      Hwdata1;
  logic [DW-1:0]      Hwdata2;
  logic               Hwritereg;
  logic [NUM_SLV-1:0] tempselx;
  logic [DW-1:0]      Hrdata;
  logic [1:0]         Hresp;
  logic               Hreadyout;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, tempselx,
           Hrdata, Hresp, Hreadyout
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, tempselx,
           Hrdata, Hresp, Hreadyout
  );
endinterface

// File: rtl/ahb_addr_decoder.sv
// Maps an AHB address onto NUM_SLV equal power-of-two regions starting at
// BASE_ADDR; produces a hit flag and a one-hot (or all-zero) slave select.
module ahb_addr_decoder #(
  parameter int            AW        = 32,
  parameter int            NUM_SLV   = 3,
  parameter logic [AW-1:0] BASE_ADDR = 'h8000_0000,
  parameter logic [AW-1:0] REGION_SZ = 'h0400_0000
) (
  input  logic [AW-1:0]      Haddr,
  output logic               hit,
  output logic [NUM_SLV-1:0] tempselx
);

  localparam int SHIFT = $clog2(REGION_SZ);
  // One extra bit so the decoded span cannot wrap past 2^AW.
  localparam logic [AW:0] SPAN = (AW+1)'(NUM_SLV) * {1'b0, REGION_SZ};

  logic [AW-1:0] offset;
  logic [AW-1:0] idx;

  always_comb begin
    offset   = Haddr - BASE_ADDR;
    hit      = (Haddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    idx      = offset >> SHIFT;
    tempselx = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit && (idx == AW'(i))) tempselx[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb_slave_if_param.sv
// AHB slave front end of the AHB-to-APB bridge: transfer qualification, region
// decode, PIPE_DEPTH address/data pipeline. Optional error FSM: AHB_SLV_ERR_RESP_EN.
//
// state   | meaning
// ST_IDLE | accepting transfers, OKAY, ready
// ST_ERR1 | first ERROR cycle for an unmapped transfer, wait state
// ST_ERR2 | second ERROR cycle, ready
module ahb_slave_if_param
  import ahb_bridge_pkg::*;
#(
  parameter int            AW         = 32,
  parameter int            DW         = 32,
  parameter int            NUM_SLV    = 3,
  parameter logic [AW-1:0] BASE_ADDR  = 'h8000_0000,
  parameter logic [AW-1:0] REGION_SZ  = 'h0400_0000,
  parameter int            PIPE_DEPTH = 2
) (
  input logic                 Hclk,
  input logic                 Hresetn,
  ahb_slave_if_param_if.slave bus
);

  logic hit;
  logic active;
  logic fsm_idle;

  assign active = (bus.Htrans == HTRANS_NONSEQ) || (bus.Htrans == HTRANS_SEQ);

  ahb_addr_decoder #(
    .AW        (AW),
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .REGION_SZ (REGION_SZ)
  ) u_dec (
    .Haddr    (bus.Haddr),
    .hit      (hit),
    .tempselx (bus.tempselx)
  );

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_pipe
    logic [AW-1:0] addr_r;
    logic [DW-1:0] data_r;
    logic [AW-1:0] addr_prev;
    logic [DW-1:0] data_prev;

    if (k == 0) begin : g_src
      assign addr_prev = bus.Haddr;
      assign data_prev = bus.Hwdata;
    end else begin : g_src
      assign addr_prev = g_pipe[k-1].addr_r;
      assign data_prev = g_pipe[k-1].data_r;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
        addr_r <= '0;
        data_r <= '0;
      end else if (bus.Hreadyin) begin
        addr_r <= addr_prev;
        data_r <= data_prev;
      end
    end
  end

  assign bus.Haddr1  = g_pipe[0].addr_r;
  assign bus.Haddr2  = g_pipe[PIPE_DEPTH-1].addr_r;
  assign bus.Hwdata1 = g_pipe[0].data_r;
  assign bus.Hwdata2 = g_pipe[PIPE_DEPTH-1].data_r;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn)          bus.Hwritereg <= 1'b0;
    else if (bus.Hreadyin) bus.Hwritereg <= bus.Hwrite;
  end

  assign bus.Hrdata = bus.Prdata;
  assign bus.valid  = bus.Hreadyin & hit & active & fsm_idle;

`ifdef AHB_SLV_ERR_RESP_EN
  err_state_e state, state_nxt;
  logic [1:0] hresp;
  logic       hready;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Once an error starts, both ERROR cycles complete regardless of Htrans.
  always_comb begin
    state_nxt = state;
    hresp     = HRESP_OKAY;
    hready    = 1'b1;
    case (state)
      ST_IDLE: if (bus.Hreadyin && !hit && active) state_nxt = ST_ERR1;
      ST_ERR1: begin
        state_nxt = ST_ERR2;
        hresp     = HRESP_ERROR;
        hready    = 1'b0;
      end
      ST_ERR2: begin
        state_nxt = ST_IDLE;
        hresp     = HRESP_ERROR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fsm_idle      = (state == ST_IDLE);
  assign bus.Hresp     = hresp;
  assign bus.Hreadyout = hready;
`else
  assign fsm_idle      = 1'b1;
  assign bus.Hresp     = HRESP_OKAY;
  assign bus.Hreadyout = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Directed bench for ahb_slave_if_param (default parameters); expectations follow
// the build's AHB_SLV_ERR_RESP_EN setting.
module tb_ahb_slave_if_param;

  logic Hclk;
  logic Hresetn;
  int   n_vec;
  int   n_bad;

  ahb_slave_if_param_if #(.AW(32), .DW(32), .NUM_SLV(3)) bus ();

  ahb_slave_if_param dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [31:0] wd);
    bus.Hreadyin = rdy;
    bus.Htrans   = tr;
    bus.Haddr    = a;
    bus.Hwrite   = wr;
    bus.Hwdata   = wd;
    #1;
  endtask

`ifdef AHB_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  initial begin
    n_vec = 0;
    n_bad = 0;
    Hresetn    = 1'b0;
    bus.Prdata = 32'h0;
    drive(1'b1, 2'b00, 32'h0, 1'b0, 32'h0);

    // reset
    step(); step();
    chk("rst_haddr1", bus.Haddr1, 32'h0);
    chk("rst_haddr2", bus.Haddr2, 32'h0);
    chk("rst_hwritereg", bus.Hwritereg, 1'b0);
    chk("rst_hresp", bus.Hresp, 2'b00);
    chk("rst_hreadyout", bus.Hreadyout, 1'b1);
    chk("rst_valid", bus.valid, 1'b0);
    Hresetn = 1'b1;

    // mapped NONSEQ write to region 1
    drive(1'b1, 2'b10, 32'h8400_0010, 1'b1, 32'hA5A5_0001);
    chk("t2_valid", bus.valid, 1'b1);
    chk("t2_sel", bus.tempselx, 3'b010);
    step();
    chk("t2_haddr1", bus.Haddr1, 32'h8400_0010);
    chk("t2_hwdata1", bus.Hwdata1, 32'hA5A5_0001);
    chk("t2_hwritereg", bus.Hwritereg, 1'b1);
    chk("t2_haddr2_early", bus.Haddr2, 32'h0);
    drive(1'b1, 2'b00, 32'h0000_0000, 1'b1, 32'h0000_0000);
    step();
    chk("t2_haddr2", bus.Haddr2, 32'h8400_0010);
    chk("t2_hwdata2", bus.Hwdata2, 32'hA5A5_0001);
    chk("t2_haddr1_next", bus.Haddr1, 32'h0);

    // stalled transfer holds the pipeline
    drive(1'b0, 2'b11, 32'h8040_0000, 1'b0, 32'hDEAD_BEEF);
    chk("t3_valid", bus.valid, 1'b0);
    chk("t3_sel", bus.tempselx, 3'b001);
    step();
    chk("t3_haddr1_hold", bus.Haddr1, 32'h0);
    chk("t3_haddr2_hold", bus.Haddr2, 32'h8400_0010);
    chk("t3_hwritereg_hold", bus.Hwritereg, 1'b1);

    // SEQ to region 0, read data pass-through
    bus.Prdata = 32'h1234_5678;
    drive(1'b1, 2'b11, 32'h8000_0000, 1'b0, 32'h0);
    chk("seq_valid", bus.valid, 1'b1);
    chk("seq_sel", bus.tempselx, 3'b001);
    chk("hrdata", bus.Hrdata, 32'h1234_5678);
    drive(1'b1, 2'b01, 32'h8000_0000, 1'b0, 32'h0);
    chk("busy_valid", bus.valid, 1'b0);

    // boundaries (Htrans forced to IDLE before each edge)
    drive(1'b1, 2'b10, 32'h8BFF_FFFC, 1'b0, 32'h0);
    chk("top_sel", bus.tempselx, 3'b100);
    chk("top_valid", bus.valid, 1'b1);
    drive(1'b1, 2'b10, 32'h87FF_FFFF, 1'b0, 32'h0);
    chk("r1_top_sel", bus.tempselx, 3'b010);
    drive(1'b1, 2'b10, 32'h8C00_0000, 1'b0, 32'h0);
    chk("past_top_sel", bus.tempselx, 3'b000);
    chk("past_top_valid", bus.valid, 1'b0);
    drive(1'b1, 2'b10, 32'h7FFF_FFFC, 1'b0, 32'h0);
    chk("below_sel", bus.tempselx, 3'b000);
    chk("below_valid", bus.valid, 1'b0);
    drive(1'b1, 2'b00, 32'h7FFF_FFFC, 1'b0, 32'h0);
    step();

    // unmapped NONSEQ
    drive(1'b1, 2'b10, 32'h8C00_1234, 1'b0, 32'h0);
    chk("t4_valid", bus.valid, 1'b0);
    chk("t4_sel", bus.tempselx, 3'b000);
    chk("t4_hresp0", bus.Hresp, 2'b00);
    step();
    drive(1'b1, 2'b00, 32'h8C00_1234, 1'b0, 32'h0);
    chk("t4_hresp1", bus.Hresp, ERR_EN ? 2'b01 : 2'b00);
    chk("t4_hready1", bus.Hreadyout, ERR_EN ? 1'b0 : 1'b1);
    step();
    drive(1'b1, 2'b10, 32'h8000_0004, 1'b0, 32'h0);
    chk("t4_hresp2", bus.Hresp, ERR_EN ? 2'b01 : 2'b00);
    chk("t4_hready2", bus.Hreadyout, 1'b1);
    chk("t4_valid2", bus.valid, ERR_EN ? 1'b0 : 1'b1);
    drive(1'b1, 2'b00, 32'h8000_0004, 1'b0, 32'h0);
    step();
    chk("t4_hresp3", bus.Hresp, 2'b00);
    chk("t4_hready3", bus.Hreadyout, 1'b1);

    // reset during ERR1
    drive(1'b1, 2'b10, 32'h9000_0000, 1'b0, 32'h0);
    step();
    drive(1'b1, 2'b00, 32'h9000_0000, 1'b0, 32'h0);
    chk("t6_err1_hresp", bus.Hresp, ERR_EN ? 2'b01 : 2'b00);
    Hresetn = 1'b0;
    #1;
    chk("t6_rst_hresp", bus.Hresp, 2'b00);
    chk("t6_rst_hready", bus.Hreadyout, 1'b1);
    chk("t6_rst_haddr1", bus.Haddr1, 32'h0);
    step();
    Hresetn = 1'b1;
    step();
    chk("t6_after_hresp", bus.Hresp, 2'b00);
    drive(1'b1, 2'b10, 32'h8800_0000, 1'b0, 32'h0);
    chk("t6_after_valid", bus.valid, 1'b1);
    chk("t6_after_sel", bus.tempselx, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
